// File: rtl/sobel_stream_engine.sv
// sobel_stream_engine: streaming 3x3 Sobel gradient-magnitude engine.
// Raster pixels in over valid/ready; two line buffers plus a 3x3 window
// register produce |Gx|+|Gy| (saturated) over a backpressured output port.
// Optional macro SOBEL_THRESH_EN adds thresh_i and binarises the output.
module sobel_stream_engine #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  finish_o,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_pixel_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
`ifdef SOBEL_THRESH_EN
    input  logic [DATA_WIDTH-1:0] thresh_i,
`endif
    output logic [DATA_WIDTH-1:0] out_pixel_o
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW = DATA_WIDTH + 3;
    localparam int MW = DATA_WIDTH + 4;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [MW-1:0] MAX_VAL  = {4'b0000, {DATA_WIDTH{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] lb0 [IMG_W];
    logic [DATA_WIDTH-1:0] lb1 [IMG_W];
    logic [DATA_WIDTH-1:0] win [3][3];
    logic [DATA_WIDTH-1:0] p   [3][3];
    logic                  in_hs, out_hs, last_px, complete;
    logic signed [SW-1:0]  gx, gy;
    logic [SW-1:0]         ax, ay;
    logic [MW-1:0]         mag;
    logic [DATA_WIDTH-1:0] sat, result;

    function automatic logic signed [SW-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        return signed'(SW'(v));
    endfunction

    assign in_hs    = in_valid_i && in_ready_o;
    assign out_hs   = out_valid_o && out_ready_i;
    assign last_px  = (row == ROW_LAST) && (col == COL_LAST);
    // Window needs two full rows and two full columns behind it, so it never spans a wrap.
    assign complete = in_hs && (row >= RW'(2)) && (col >= CW'(2));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state plus combinational handshake/status outputs.
    always_comb begin
        state_d    = state_q;
        in_ready_o = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN: begin
                busy_o     = 1'b1;
                in_ready_o = !out_valid_o || out_ready_i;
                if (in_hs && last_px) state_d = DRAIN;
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (out_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Window after this cycle's shift: two old columns plus the incoming column.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[r][0] = win[r][1];
            p[r][1] = win[r][2];
        end
        p[0][2] = lb1[col];
        p[1][2] = lb0[col];
        p[2][2] = in_pixel_i;
    end

    // Sobel gradients, magnitude and saturation.
    always_comb begin
        gx  = (ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2]))
            - (ext(p[0][0]) + (ext(p[1][0]) <<< 1) + ext(p[2][0]));
        gy  = (ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2]))
            - (ext(p[0][0]) + (ext(p[0][1]) <<< 1) + ext(p[0][2]));
        ax  = gx[SW-1] ? SW'(-gx) : SW'(gx);
        ay  = gy[SW-1] ? SW'(-gy) : SW'(gy);
        mag = MW'(ax) + MW'(ay);
        sat = (mag > MAX_VAL) ? {DATA_WIDTH{1'b1}} : mag[DATA_WIDTH-1:0];
`ifdef SOBEL_THRESH_EN
        result = (sat > thresh_i) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
`else
        result = sat;
`endif
    end

    // Line buffers: contents need no reset, they are always rewritten before use.
    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            lb0[col] <= in_pixel_i;
            lb1[col] <= lb0[col];
        end
    end

    // Counters, window shift, output register and finish pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col         <= '0;
            row         <= '0;
            out_valid_o <= 1'b0;
            out_pixel_o <= '0;
            finish_o    <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            finish_o <= (state_q == DRAIN) && out_hs;
            if (state_q == IDLE && start_i) begin
                col <= '0;
                row <= '0;
            end else if (in_hs) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        win[r][c] <= p[r][c];
            end
            // A new result may replace one being accepted this cycle; a stalled one is held.
            if (complete) begin
                out_valid_o <= 1'b1;
                out_pixel_o <= result;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// tb_sobel_stream_engine: directed + randomized frames on an 8x6 engine,
// checked against a frame-level Sobel model computed from whole images.
module tb_sobel_stream_engine;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int DW = 8;
    localparam int N  = W * H;
    localparam int NO = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] in_pixel = '0;
    logic          busy, finish, in_ready, out_valid;
    logic [DW-1:0] out_pixel;
`ifdef SOBEL_THRESH_EN
    logic [DW-1:0] thresh = 8'd100;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int img [N];
    int exp_q [$];
    int got_q [$];

    always #5 clk = ~clk;

    sobel_stream_engine #(.IMG_W(W), .IMG_H(H), .DATA_WIDTH(DW)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .busy_o     (busy),
        .finish_o   (finish),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_pixel_i (in_pixel),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
`ifdef SOBEL_THRESH_EN
        .thresh_i   (thresh),
`endif
        .out_pixel_o(out_pixel)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int pix(input int r, input int c);
        return img[r * W + c];
    endfunction

    // Reference: gradient magnitude for every interior centre of the stored image.
    task automatic build_expected();
        exp_q.delete();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                int gx, gy, m;
                gx = (pix(r-1, c+1) + 2*pix(r, c+1) + pix(r+1, c+1))
                   - (pix(r-1, c-1) + 2*pix(r, c-1) + pix(r+1, c-1));
                gy = (pix(r+1, c-1) + 2*pix(r+1, c) + pix(r+1, c+1))
                   - (pix(r-1, c-1) + 2*pix(r-1, c) + pix(r-1, c+1));
                m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (m > 255) m = 255;
`ifdef SOBEL_THRESH_EN
                m = (m > int'(thresh)) ? 255 : 0;
`endif
                exp_q.push_back(m);
            end
        end
    endtask

    task automatic fill_step(input int right);
        for (int i = 0; i < N; i++) img[i] = ((i % W) >= 4) ? right : 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
    endtask

    task automatic start_frame();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Streams img through the engine; abort_at > 0 stops feeding after that many inputs.
    task automatic run_frame(input string tag, input bit gaps, input bit rnd_rdy,
                             input int start_at, input int abort_at);
        int            idx  = 0;
        int            cyc  = 0;
        int            nfin = 0;
        bit            done = 1'b0;
        bit            stall = 1'b0;
        logic [DW-1:0] held = '0;
        got_q.delete();
        build_expected();
        start_frame();
        while (!done && cyc < 4000) begin
            @(posedge clk); #1;
            if (finish) begin
                nfin++;
                check({tag, "_busy_at_finish"}, busy, 0);
                done = 1'b1;
            end
            if (abort_at > 0 && idx >= abort_at) break;
            start     = (cyc == start_at);
            in_valid  = (idx < N) && (!gaps || $urandom_range(0, 3) != 0);
            in_pixel  = (idx < N) ? DW'(img[idx]) : '0;
            out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            if (stall) begin
                check({tag, "_stall_valid"}, out_valid, 1);
                check({tag, "_stall_pixel"}, out_pixel, held);
            end
            if (out_valid && !out_ready) check({tag, "_in_ready_blocked"}, in_ready, 0);
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) got_q.push_back(int'(out_pixel));
            stall = out_valid && !out_ready;
            held  = out_pixel;
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (abort_at > 0) return;
        check({tag, "_completed"}, done, 1);
        check({tag, "_count"}, got_q.size(), NO);
        for (int i = 0; i < NO; i++)
            check($sformatf("%s_px%0d", tag, i), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
        repeat (3) begin
            @(posedge clk); #1;
            if (finish) nfin++;
        end
        check({tag, "_finish_pulses"}, nfin, 1);
    endtask

    initial begin
        // Reset values while held in reset.
        #12;
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pixel", out_pixel, 0);
        rst_n = 1'b1;

        // Input offered in IDLE must not be taken.
        @(posedge clk); #1 in_valid = 1'b1; in_pixel = 8'd99;
        repeat (3) begin
            @(negedge clk);
            check("idle_in_ready", in_ready, 0);
        end
        @(posedge clk); #1 in_valid = 1'b0;

        for (int i = 0; i < N; i++) img[i] = 77;
        run_frame("const", 1'b0, 1'b0, -1, 0);

        fill_step(40);
        run_frame("step40", 1'b0, 1'b0, -1, 0);

        fill_step(200);
        run_frame("step200", 1'b0, 1'b0, -1, 0);

        fill_step(40);
        run_frame("step_bp", 1'b1, 1'b1, 15, 0);

        fill_random();
        run_frame("rand_bp", 1'b1, 1'b1, -1, 0);

        // Abort mid-frame with asynchronous reset.
        fill_random();
        run_frame("abort", 1'b0, 1'b0, -1, 20);
        @(negedge clk);
        check("abort_pre_valid", out_valid, 1);
        check("abort_pre_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        fill_random();
        run_frame("after_abort", 1'b0, 1'b1, -1, 0);

`ifdef SOBEL_THRESH_EN
        thresh = 8'd160;
        fill_step(40);
        run_frame("thresh160", 1'b0, 1'b0, -1, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
